imem_param: RTL and testbench

Parametrised instruction memory for the RISC-V core's fetch stage. It replaces the fixed 40-byte reset-initialised ROM with a word-organised, byte-enabled 1R1W array. On reset it auto-fills with NOPs, then accepts program writes through a load port. Fetches use a valid/ready handshake with one-cycle registered latency, and each response carries a fault code for misaligned or out-of-range PCs.

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_param_if.sv | 27 ++
 rtl/imem_array.sv | 29 ++
 rtl/imem_param.sv | 136 +++++++++++++
 tb/tb_imem_param.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared constants and encodings for the parametrised instruction memory.
package imem_pkg;

  // RISC-V canonical NOP (addi x0, x0, 0), used for fill and for faulted fetches.
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_e;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/imem_param_if.sv
// Fetch (valid/ready request + registered response) and program-load port bundle.
interface imem_param_if #(
  parameter int PC_W = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [PC_W-1:0] req_pc;
  logic            resp_valid;
  logic            resp_ready;
  logic [31:0]     resp_inst;
  logic [1:0]      resp_fault;
  logic            prog_we;
  logic            prog_ready;
  logic [PC_W-1:0] prog_addr;
  logic [31:0]     prog_wdata;
  logic [3:0]      prog_be;

  modport master (
    output req_valid, req_pc, resp_ready, prog_we, prog_addr, prog_wdata, prog_be,
    input  req_ready, resp_valid, resp_inst, resp_fault, prog_ready
  );

  modport slave (
    input  req_valid, req_pc, resp_ready, prog_we, prog_addr, prog_wdata, prog_be,
    output req_ready, resp_valid, resp_inst, resp_fault, prog_ready
  );
endinterface

// File: rtl/imem_array.sv
// Word-organised storage: one synchronous byte-enabled write port, one
// asynchronous read port. No reset; contents come from the fill sequence.
module imem_array #(
  parameter  int DEPTH_WORDS = 256,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [31:0]      wdata,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] ridx,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write; lanes with be cleared keep their old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/imem_param.sv
// Instruction memory top: NOP fill sequencer, program-port write mux,
// fetch fault checks and the one-deep registered response.
module imem_param
  import imem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 256,
  parameter  int PC_W        = 32,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_param_if.slave  bus,
  output logic         init_done
);

  localparam logic [PC_W-3:0]  DEPTH_LIM = (PC_W-2)'(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] CNT_LAST  = IDX_W'(DEPTH_WORDS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic [PC_W-3:0]  req_word, prog_word;
  logic             req_in_range, prog_in_range, running, req_fire;

  logic             arr_we;
  logic [IDX_W-1:0] arr_widx;
  logic [31:0]      arr_wdata, arr_rdata;
  logic [3:0]       arr_be;

  logic             resp_valid_q;
  logic [31:0]      resp_inst_q, inst_d;
  fault_e           resp_fault_q, fault_d;

  // Byte-offset bits of the program address carry no meaning.
  logic             unused_prog_lsb;
  assign unused_prog_lsb = ^bus.prog_addr[1:0];

  assign req_word      = bus.req_pc[PC_W-1:2];
  assign prog_word     = bus.prog_addr[PC_W-1:2];
  assign req_in_range  = req_word < DEPTH_LIM;
  assign prog_in_range = prog_word < DEPTH_LIM;
  assign running       = (state_q == ST_RUN);

  // Program writes take priority: a fetch is held off while prog_we is high.
  assign bus.req_ready  = running && !bus.prog_we && (!resp_valid_q || bus.resp_ready);
  assign bus.prog_ready = running;
  assign init_done      = running;
  assign req_fire       = bus.req_valid && bus.req_ready;

  // FSM state and fill counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: walk every word once in FILL, then stay in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_FILL: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN:  cnt_d = '0;
      default: state_d = ST_FILL;
    endcase
  end

  // Write port mux: fill counter owns the array until RUN; out-of-range program writes are dropped.
  always_comb begin
    arr_we    = 1'b0;
    arr_widx  = prog_word[IDX_W-1:0];
    arr_wdata = bus.prog_wdata;
    arr_be    = bus.prog_be;
    if (state_q == ST_FILL) begin
      arr_we    = 1'b1;
      arr_widx  = cnt_q;
      arr_wdata = INST_NOP;
      arr_be    = 4'hF;
    end else begin
      arr_we = bus.prog_we && prog_in_range;
    end
  end

  imem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .widx  (arr_widx),
    .wdata (arr_wdata),
    .be    (arr_be),
    .ridx  (req_word[IDX_W-1:0]),
    .rdata (arr_rdata)
  );

  // Fault classification; misalignment is checked before range.
  always_comb begin
    fault_d = FAULT_NONE;
    inst_d  = arr_rdata;
    if (bus.req_pc[1:0] != 2'b00) begin
      fault_d = FAULT_MISALIGN;
      inst_d  = INST_NOP;
    end else if (!req_in_range) begin
      fault_d = FAULT_RANGE;
      inst_d  = INST_NOP;
    end
  end

  // Response register: load on accept, hold under backpressure, drop valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_inst_q  <= INST_NOP;
      resp_fault_q <= FAULT_NONE;
    end else if (req_fire) begin
      resp_valid_q <= 1'b1;
      resp_inst_q  <= inst_d;
      resp_fault_q <= fault_d;
    end else if (bus.resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_inst  = resp_inst_q;
  assign bus.resp_fault = resp_fault_q;

endmodule

// File: tb/tb_imem_param.sv
// Directed bench for imem_param with DEPTH_WORDS=16.
module tb_imem_param;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n;

  imem_param_if #(.PC_W(32)) bus ();

  imem_param #(.DEPTH_WORDS(16), .PC_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fill(input string tag);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (init_done) break;
    end
    check(tag, n, 16);
  endtask

  task automatic prog_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    bus.prog_we = 1'b1;
    bus.prog_addr = addr;
    bus.prog_wdata = data;
    bus.prog_be = be;
    bus.req_valid = 1'b1;
    bus.req_pc = 32'h0;
    #1;
    check("wr_blocks_fetch", {31'b0, bus.req_ready}, 32'd0);
    check("wr_prog_ready", {31'b0, bus.prog_ready}, 32'd1);
    tick();
    bus.prog_we = 1'b0;
    bus.req_valid = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [31:0] pc, input logic [31:0] ei, input logic [1:0] ef);
    bus.req_valid = 1'b1;
    bus.req_pc = pc;
    bus.resp_ready = 1'b1;
    #1;
    check({tag, "_rdy"}, {31'b0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 1'b0;
    check({tag, "_valid"}, {31'b0, bus.resp_valid}, 32'd1);
    check({tag, "_inst"}, bus.resp_inst, ei);
    check({tag, "_fault"}, {30'b0, bus.resp_fault}, {30'b0, ef});
    tick();
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_pc = '0;
    bus.resp_ready = 1'b0;
    bus.prog_we = 1'b0;
    bus.prog_addr = '0;
    bus.prog_wdata = '0;
    bus.prog_be = '0;

    repeat (2) tick();
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    check("rst_prog_ready", {31'b0, bus.prog_ready}, 32'd0);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_resp_inst", bus.resp_inst, NOP);
    check("rst_resp_fault", {30'b0, bus.resp_fault}, 32'd0);
    check("rst_init_done", {31'b0, init_done}, 32'd0);
    rst_n = 1'b1;
    wait_fill("fill_cycles");

    fetch("nop_pc0", 32'h0, NOP, 2'b00);

    prog_write(32'h0, 32'h0088_a783, 4'hF);
    fetch("prog_pc0", 32'h0, 32'h0088_a783, 2'b00);

    prog_write(32'h4, 32'h1122_3344, 4'b0101);
    fetch("byte_en", 32'h4, 32'h0022_0044, 2'b00);

    prog_write(32'h40, 32'hDEAD_BEEF, 4'hF);
    fetch("oor_write_dropped", 32'h0, 32'h0088_a783, 2'b00);

    prog_write(32'h4, 32'h0017_9793, 4'hF);
    bus.req_valid = 1'b1;
    bus.req_pc = 32'h0;
    bus.resp_ready = 1'b1;
    tick();
    check("b2b_0_valid", {31'b0, bus.resp_valid}, 32'd1);
    check("b2b_0_inst", bus.resp_inst, 32'h0088_a783);
    check("b2b_rdy", {31'b0, bus.req_ready}, 32'd1);
    bus.req_pc = 32'h4;
    tick();
    check("b2b_1_valid", {31'b0, bus.resp_valid}, 32'd1);
    check("b2b_1_inst", bus.resp_inst, 32'h0017_9793);
    bus.req_valid = 1'b0;
    tick();
    check("b2b_drain", {31'b0, bus.resp_valid}, 32'd0);

    fetch("mis_pc2", 32'h2, NOP, 2'b01);
    fetch("oor_pc40", 32'h40, NOP, 2'b10);
    fetch("mis_pc42", 32'h42, NOP, 2'b01);
    fetch("last_pc3c", 32'h3C, NOP, 2'b00);

    bus.resp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_pc = 32'h0;
    tick();
    check("bp_first_inst", bus.resp_inst, 32'h0088_a783);
    bus.req_pc = 32'h4;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", {31'b0, bus.resp_valid}, 32'd1);
      check("bp_inst", bus.resp_inst, 32'h0088_a783);
      check("bp_fault", {30'b0, bus.resp_fault}, 32'd0);
      check("bp_req_ready", {31'b0, bus.req_ready}, 32'd0);
    end
    bus.resp_ready = 1'b1;
    #1;
    check("bp_release_rdy", {31'b0, bus.req_ready}, 32'd1);
    tick();
    check("bp_next_valid", {31'b0, bus.resp_valid}, 32'd1);
    check("bp_next_inst", bus.resp_inst, 32'h0017_9793);
    bus.req_valid = 1'b0;
    tick();

    bus.resp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_pc = 32'h0;
    tick();
    bus.req_valid = 1'b0;
    check("pend_valid", {31'b0, bus.resp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_pend_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_pend_init", {31'b0, init_done}, 32'd0);
    check("rst_pend_inst", bus.resp_inst, NOP);
    tick();
    rst_n = 1'b1;
    repeat (7) tick();
    check("midfill_init", {31'b0, init_done}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("midfill_rst_init", {31'b0, init_done}, 32'd0);
    check("midfill_rst_rdy", {31'b0, bus.req_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    wait_fill("refill_cycles");
    fetch("refill_pc0", 32'h0, NOP, 2'b00);
    fetch("refill_pc4", 32'h4, NOP, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
